pipe_adder: RTL and testbench

- Parametrised, pipelined add/subtract unit; the next generation of the team's single-bit full adder cell.
- Splits a WIDTH-bit operation into STAGES ripple chunks, one per register stage, with the carry passed between stages.
- Uses valid/ready flow control so it drops into streaming datapaths and sustains one operation per clock.
- Outputs sum, carry-out and signed overflow.

---
 rtl/pipe_adder_pkg.sv | 20 ++
 rtl/add_chunk.sv | 24 ++
 rtl/pipe_adder.sv | 124 ++++++++++++
 tb/tb_pipe_adder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
package pipe_adder_pkg;

  // Per-stage control payload travelling alongside the sum and operand words.
  typedef struct packed {
    logic carry;
    logic ovf;
  } stage_flags_t;

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  // Two's-complement overflow: operands agree in sign but the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple adder built from a chain of full-adder cells.
module add_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o
);

  logic carry;

  always_comb begin
    carry = c_i;
    s_o   = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract with valid/ready flow control; one CHUNK ripple slice per stage.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if ((STAGES < 1) || (WIDTH < 2) || (WIDTH % STAGES != 0)) begin : g_param_check
    $error("pipe_adder: WIDTH must be >= 2 and a multiple of STAGES");
  end

  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic              c_in [STAGES];
  logic [CHUNK-1:0]  chunk_sum [STAGES];
  logic              chunk_cout [STAGES];

  logic [WIDTH-1:0]  a_q [STAGES], a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES], b_d [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES], sum_d [STAGES];
  stage_flags_t      flags_q [STAGES], flags_d [STAGES];
  logic [STAGES-1:0] valid_q, valid_d, src_valid;
  // take[k]: stage k may load this cycle; take[STAGES] is the downstream sink.
  logic [STAGES:0]   take;

  always_comb begin : stage_inputs
    a_in[0]      = A;
    b_in[0]      = B ^ {WIDTH{sub}};
    s_in[0]      = '0;
    c_in[0]      = Cin ^ sub;
    src_valid[0] = in_valid;
    for (int k = 1; k < int'(STAGES); k++) begin
      a_in[k]      = a_q[k-1];
      b_in[k]      = b_q[k-1];
      s_in[k]      = sum_q[k-1];
      c_in[k]      = flags_q[k-1].carry;
      src_valid[k] = valid_q[k-1];
    end
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    add_chunk #(
      .CHUNK(CHUNK)
    ) u_add_chunk (
      .a_i(a_in[k][k*CHUNK +: CHUNK]),
      .b_i(b_in[k][k*CHUNK +: CHUNK]),
      .c_i(c_in[k]),
      .s_o(chunk_sum[k]),
      .c_o(chunk_cout[k])
    );
  end

  // Backward ready chain: a stage can load if empty or its contents move on this cycle.
  always_comb begin : handshake
    take[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      take[k] = !valid_q[k] || take[k+1];
    end
  end

  assign in_ready = take[0] && !rst;

  always_comb begin : next_state
    for (int k = 0; k < int'(STAGES); k++) begin
      valid_d[k] = take[k] ? src_valid[k] : valid_q[k];
      a_d[k]     = a_q[k];
      b_d[k]     = b_q[k];
      sum_d[k]   = sum_q[k];
      flags_d[k] = flags_q[k];
      if (take[k] && src_valid[k]) begin
        a_d[k]                     = a_in[k];
        b_d[k]                     = b_in[k];
        sum_d[k]                   = s_in[k];
        sum_d[k][k*CHUNK +: CHUNK] = chunk_sum[k];
        flags_d[k].carry           = chunk_cout[k];
        flags_d[k].ovf             = (k == int'(STAGES) - 1) &&
                                     signed_ovf(a_in[k][WIDTH-1], b_in[k][WIDTH-1],
                                                chunk_sum[k][CHUNK-1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        flags_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign S         = sum_q[STAGES-1];
  assign Cout      = flags_q[STAGES-1].carry;
  assign Ovf       = flags_q[STAGES-1].ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: 8-bit/2-stage and 32-bit/4-stage instances against an arithmetic model.
module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT 1: WIDTH=8, STAGES=2
  logic       iv1 = 0, ir1, ov1, or1 = 1, cin1 = 0, sub1 = 0, co1, ovf1;
  logic [7:0] a1 = 0, b1 = 0, s1;
  // DUT 2: WIDTH=32, STAGES=4
  logic        iv2 = 0, ir2, ov2, or2 = 1, cin2 = 0, sub2 = 0, co2, ovf2;
  logic [31:0] a2 = 0, b2 = 0, s2;

  pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1), .Cin(cin1),
    .sub(sub1), .out_valid(ov1), .out_ready(or1), .S(s1), .Cout(co1), .Ovf(ovf1)
  );

  pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2), .Cin(cin2),
    .sub(sub2), .out_valid(ov2), .out_ready(or2), .S(s2), .Cout(co2), .Ovf(ovf2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  longint q1[$];
  longint q2[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Packed expectation {S, Cout, Ovf} from plain integer arithmetic.
  function automatic longint model(input int w, input longint a, input longint b,
                                   input bit cin, input bit sb);
    longint full, half, r, sa, sb_s, sr;
    bit co, ov;
    full = longint'(1) << w;
    half = full >> 1;
    if (!sb) begin
      r  = a + b + longint'(cin);
      co = (r >= full);
    end else begin
      r  = a - b - longint'(cin);
      co = (r >= 0);
    end
    sa   = (a >= half) ? a - full : a;
    sb_s = (b >= half) ? b - full : b;
    sr   = sb ? sa - sb_s - longint'(cin) : sa + sb_s + longint'(cin);
    ov   = (sr >= half) || (sr < -half);
    return ((r & (full - 1)) << 2) | (longint'(co) << 1) | longint'(ov);
  endfunction

  // Scoreboards: outputs checked every cycle they are valid (also catches instability).
  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
    end else begin
      if (ov1) begin
        if (q1.size() == 0) begin
          n_checks++;
          $display("FAIL dut1 unexpected output: got 0x%0h, expected none", {s1, co1, ovf1});
        end else begin
          check("dut1 result", longint'({s1, co1, ovf1}), q1[0]);
          if (or1) void'(q1.pop_front());
        end
      end
      if (iv1 && ir1) q1.push_back(model(8, longint'(a1), longint'(b1), cin1, sub1));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q2.delete();
    end else begin
      if (ov2) begin
        if (q2.size() == 0) begin
          n_checks++;
          $display("FAIL dut2 unexpected output: got 0x%0h, expected none", {s2, co2, ovf2});
        end else begin
          check("dut2 result", longint'({s2, co2, ovf2}), q2[0]);
          if (or2) void'(q2.pop_front());
        end
      end
      if (iv2 && ir2) q2.push_back(model(32, longint'(a2), longint'(b2), cin2, sub2));
    end
  end

  // Present a beat at posedge+1 and return at posedge+1 after it was taken.
  task automatic send1(input logic [7:0] a, input logic [7:0] b, input bit c, input bit sb);
    bit got = 0;
    a1 = a; b1 = b; cin1 = c; sub1 = sb; iv1 = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ir1) begin got = 1; break; end
    end
    if (!got) check("dut1 accept timeout", longint'(got), 1);
    @(posedge clk); #1;
  endtask

  task automatic send2(input logic [31:0] a, input logic [31:0] b, input bit c, input bit sb);
    bit got = 0;
    a2 = a; b2 = b; cin2 = c; sub2 = sb; iv2 = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ir2) begin got = 1; break; end
    end
    if (!got) check("dut2 accept timeout", longint'(got), 1);
    @(posedge clk); #1;
  endtask

  // Wait for a result (out_ready=1), check a literal, report edges since the accepting edge.
  task automatic wait_out1(input string name, input longint exp, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ov1 && lat < 20);
    check(name, longint'({s1, co1, ovf1}), exp);
    @(posedge clk); #1;
  endtask

  task automatic wait_out2(input string name, input longint exp, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ov2 && lat < 20);
    check(name, longint'({s2, co2, ovf2}), exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, cnt;
    logic [7:0] held;

    // Hand-computed values that pin the model.
    check("model ff+01", model(8, 'hFF, 'h01, 0, 0), ('h00 << 2) | 2);
    check("model 7f+01", model(8, 'h7F, 'h01, 0, 0), ('h80 << 2) | 1);
    check("model 80+80", model(8, 'h80, 'h80, 0, 0), ('h00 << 2) | 3);
    check("model 05-07", model(8, 'h05, 'h07, 0, 1), ('hFE << 2) | 0);
    check("model 10-01-1", model(8, 'h10, 'h01, 1, 1), ('h0E << 2) | 2);

    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset out_valid", ov1, 0);
    check("reset in_ready", ir1, 1);
    check("reset S/Cout/Ovf", longint'({s1, co1, ovf1}), 0);
    check("reset dut2 out_valid", ov2, 0);
    check("reset dut2 in_ready", ir2, 1);
    @(posedge clk); #1;

    // Directed arithmetic cases.
    send1(8'hFF, 8'h01, 0, 0); iv1 = 0;
    wait_out1("basic carry", ('h00 << 2) | 2, lat);
    check("latency 8/2", lat, 2);
    send1(8'h7F, 8'h01, 0, 0); iv1 = 0;
    wait_out1("ovf 7f+01", ('h80 << 2) | 1, lat);
    send1(8'h80, 8'h80, 0, 0); iv1 = 0;
    wait_out1("ovf 80+80", ('h00 << 2) | 3, lat);
    send1(8'h05, 8'h07, 0, 1); iv1 = 0;
    wait_out1("sub borrow", ('hFE << 2) | 0, lat);
    send1(8'h10, 8'h01, 1, 1); iv1 = 0;
    wait_out1("sub cin", ('h0E << 2) | 2, lat);

    // Throughput: 16 back-to-back beats give 16 consecutive outputs.
    fork
      begin
        for (int i = 0; i < 16; i++)
          send1(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        iv1 = 0;
      end
      begin
        int k = 0;
        do begin @(negedge clk); k++; end while (!ov1 && k < 20);
        for (int i = 0; i < 16; i++) begin
          check($sformatf("throughput beat %0d valid", i), ov1, 1);
          if (i < 15) @(negedge clk);
        end
      end
    join
    repeat (3) @(posedge clk); #1;
    check("throughput drained", q1.size(), 0);

    // Backpressure: only two slots fill, output held stable.
    or1 = 0; iv1 = 1;
    a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom);
    held = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp in_ready cycle %0d", c), ir1, longint'(c < 2));
      if (c == 2) held = s1;
      if (c == 4) check("bp S stable", s1, held);
      @(posedge clk); #1;
      if (c < 2) begin
        a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom);
      end
    end
    iv1 = 0; or1 = 1; cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ov1) cnt++;
    end
    check("bp release output count", cnt, 2);
    @(posedge clk); #1;

    // Random traffic with random backpressure on both instances.
    for (int c = 0; c < 120; c++) begin
      iv1 = ($urandom % 4) != 0; or1 = ($urandom % 3) != 0;
      a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom);
      iv2 = ($urandom % 4) != 0; or2 = ($urandom % 3) != 0;
      a2 = $urandom; b2 = $urandom; cin2 = 1'($urandom); sub2 = 1'($urandom);
      if (c % 40 == 0) begin a2 = 32'h8000_0000; b2 = 32'h7FFF_FFFF; end
      @(posedge clk); #1;
    end
    iv1 = 0; or1 = 1; iv2 = 0; or2 = 1;
    repeat (10) @(posedge clk); #1;
    check("random dut1 drained", q1.size(), 0);
    check("random dut2 drained", q2.size(), 0);

    // Reset mid-flight: two beats held, reset discards them; a beat during reset is refused.
    or1 = 0;
    send1(8'h11, 8'h22, 0, 0);
    send1(8'h33, 8'h44, 0, 0);
    a1 = 8'h55; b1 = 8'h66; rst = 1;
    @(negedge clk);
    check("in_ready during reset", ir1, 0);
    @(posedge clk); #1;
    rst = 0; iv1 = 0; or1 = 1;
    @(negedge clk);
    check("post-reset out_valid", ov1, 0);
    check("post-reset in_ready", ir1, 1);
    check("post-reset S/Cout/Ovf", longint'({s1, co1, ovf1}), 0);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ov1) cnt++;
    end
    check("flushed beats never appear", cnt, 0);
    @(posedge clk); #1;

    // 32-bit, 4-stage basic carry.
    send2(32'hFFFF_FFFF, 32'h0000_0001, 0, 0); iv2 = 0;
    wait_out2("basic carry 32/4", 2, lat);
    check("latency 32/4", lat, 4);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
